// File: rtl/router_pkg.sv
// Shared router constants: header field widths, reserved address and packet-source states.
package router_pkg;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 6;
    localparam int ADDR_W = 2;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PLD  = 2'd2,
        ST_PAR  = 2'd3
    } pkt_src_state_t;

    function automatic logic [DATA_W-1:0] make_hdr(input logic [LEN_W-1:0]  len,
                                                   input logic [ADDR_W-1:0] dest);
        return {len, dest};
    endfunction

endpackage

// File: rtl/router_pkt_src_if.sv
// Load, start and router-side handshake bundle of the packet source.
interface router_pkt_src_if #(
    parameter int CNT_W = 16
);
    import router_pkg::*;

    logic                  ld_valid;
    logic [DATA_W-1:0]     ld_data;
    logic                  ld_ready;
    logic                  start;
    logic [ADDR_W-1:0]     start_dest;
    logic                  start_err_inj;
    logic                  start_ready;
    logic                  busy;
    logic                  pkt_valid;
    logic [DATA_W-1:0]     pkt_data;
    logic                  done;
    logic                  start_err;
    logic [CNT_W-1:0]      pkt_count;

    modport master (
        input  ld_valid, ld_data, start, start_dest, start_err_inj, busy,
        output ld_ready, start_ready, pkt_valid, pkt_data, done, start_err, pkt_count
    );

    modport slave (
        output ld_valid, ld_data, start, start_dest, start_err_inj, busy,
        input  ld_ready, start_ready, pkt_valid, pkt_data, done, start_err, pkt_count
    );

endinterface

// File: rtl/router_pkt_buf.sv
// Payload byte store: one synchronous write port, one combinational read port.
module router_pkt_buf
    import router_pkg::*;
#(
    parameter int MAX_LEN = 63
) (
    input  logic              clock,
    input  logic              i_we,
    input  logic [LEN_W-1:0]  i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [LEN_W-1:0]  i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    localparam logic [LEN_W-1:0] LAST_ADDR = LEN_W'(MAX_LEN - 1);

    logic [DATA_W-1:0] r_mem [MAX_LEN];

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Addresses past the array return zero instead of reading out of range.
    assign o_rd_data = (i_rd_addr <= LAST_ADDR) ? r_mem[i_rd_addr] : '0;

endmodule

// File: rtl/router_pkt_src.sv
// Packet source for router_top: buffers a payload, then emits header, payload and parity.
module router_pkt_src
    import router_pkg::*;
#(
    parameter int MAX_LEN = 63,   // at most 63: the header length field is 6 bits
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    router_pkt_src_if.master bus
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    pkt_src_state_t    r_state;
    logic [LEN_W-1:0]  r_count;
    logic [LEN_W-1:0]  r_rd_ptr;
    logic [DATA_W-1:0] r_parity;
    logic [DATA_W-1:0] r_pkt_data;
    logic              r_pkt_valid;
    logic              r_err_inj;
    logic              r_done;
    logic              r_start_err;
    logic [CNT_W-1:0]  r_pkt_count;

    logic              w_ld_ready;
    logic              w_ld_fire;
    logic [LEN_W-1:0]  w_count_eff;
    logic [DATA_W-1:0] w_rd_data;

    assign w_ld_ready  = (r_state == ST_IDLE) && (r_count < LEN_MAX);
    assign w_ld_fire   = bus.ld_valid && w_ld_ready;
    // A load in the same cycle as a start is counted into that packet.
    assign w_count_eff = r_count + {{(LEN_W-1){1'b0}}, w_ld_fire};

    router_pkt_buf #(
        .MAX_LEN (MAX_LEN)
    ) u_buf (
        .clock     (clock),
        .i_we      (w_ld_fire),
        .i_wr_addr (r_count),
        .i_wr_data (bus.ld_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_parity    <= '0;
            r_pkt_data  <= '0;
            r_pkt_valid <= 1'b0;
            r_err_inj   <= 1'b0;
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ld_fire) begin
                        r_count <= w_count_eff;
                    end
                    if (bus.start) begin
                        if ((w_count_eff == '0) || (bus.start_dest == ADDR_INVALID)) begin
                            r_start_err <= 1'b1;
                        end else begin
                            r_state     <= ST_HDR;
                            r_pkt_valid <= 1'b1;
                            r_pkt_data  <= make_hdr(w_count_eff, bus.start_dest);
                            r_parity    <= make_hdr(w_count_eff, bus.start_dest);
                            r_err_inj   <= bus.start_err_inj;
                            r_rd_ptr    <= '0;
                        end
                    end
                end
                ST_HDR, ST_PLD: begin
                    if (!bus.busy) begin
                        if (r_rd_ptr < r_count) begin
                            r_pkt_data <= w_rd_data;
                            r_parity   <= r_parity ^ w_rd_data;
                            r_rd_ptr   <= r_rd_ptr + 1'b1;
                            r_state    <= ST_PLD;
                        end else begin
                            r_state     <= ST_PAR;
                            r_pkt_valid <= 1'b0;
                            r_pkt_data  <= r_parity ^ {DATA_W{r_err_inj}};
                        end
                    end
                end
                ST_PAR: begin
                    if (!bus.busy) begin
                        r_state     <= ST_IDLE;
                        r_pkt_data  <= '0;
                        r_done      <= 1'b1;
                        r_pkt_count <= r_pkt_count + 1'b1;
                        r_count     <= '0;
                        r_rd_ptr    <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ld_ready    = w_ld_ready;
    assign bus.start_ready = (r_state == ST_IDLE);
    assign bus.pkt_valid   = r_pkt_valid;
    assign bus.pkt_data    = r_pkt_data;
    assign bus.done        = r_done;
    assign bus.start_err   = r_start_err;
    assign bus.pkt_count   = r_pkt_count;

endmodule

// File: tb/tb_router_pkt_src.sv
// Bench for router_pkt_src: table-driven packets, corner sequences and random packets vs a stream model.
module tb_router_pkt_src;
    import router_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    router_pkt_src_if #(.CNT_W(16)) bus ();

    router_pkt_src #(
        .MAX_LEN (63),
        .CNT_W   (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         len;
        logic [1:0] dest;
        bit         inj;
        int         base;       // first payload byte, incrementing; -1 for random bytes
        int         busy_pct;
        int         stall_at;   // stream index to hold with busy, -1 for none
        int         stall_len;
        int         exp_hdr;    // -1: take from the model
        int         exp_par;    // -1: take from the model
    } vec_t;

    int         n_vec    = 0;
    int         n_err    = 0;
    int         exp_pkts = 0;
    logic [7:0] pay[$];
    vec_t       tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fill(input int n, input int base);
        pay.delete();
        for (int i = 0; i < n; i++) begin
            if (base >= 0) pay.push_back(8'(base + i));
            else           pay.push_back(8'($urandom));
        end
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            chk("ld_ready", bus.ld_ready, 1'b1);
            bus.ld_valid = 1'b1;
            bus.ld_data  = pay[i];
            @(negedge clock);
        end
        bus.ld_valid = 1'b0;
    endtask

    task automatic reject(input logic [1:0] dest);
        bus.start      = 1'b1;
        bus.start_dest = dest;
        @(negedge clock);
        bus.start = 1'b0;
        chk("start_err_pulse", bus.start_err, 1'b1);
        chk("rej_pkt_valid", bus.pkt_valid, 1'b0);
        chk("rej_start_ready", bus.start_ready, 1'b1);
        @(negedge clock);
        chk("start_err_clear", bus.start_err, 1'b0);
    endtask

    // Expected stream: header {len,dest}, every payload byte, then XOR of all of them.
    task automatic send(input logic [1:0] dest, input bit inj, input int busy_pct,
                        input int stall_at, input int stall_len, input bit co_load,
                        input int hdr_k, input int par_k);
        logic [7:0] exp[$];
        logic [7:0] par;
        int k, stalls, cyc, total;
        exp.delete();
        exp.push_back({6'(pay.size()), dest});
        foreach (pay[i]) exp.push_back(pay[i]);
        par = 8'h00;
        foreach (exp[i]) par ^= exp[i];
        exp.push_back(inj ? ~par : par);
        if (hdr_k >= 0) exp[0] = 8'(hdr_k);
        if (par_k >= 0) exp[exp.size()-1] = 8'(par_k);

        bus.start         = 1'b1;
        bus.start_dest    = dest;
        bus.start_err_inj = inj;
        if (co_load) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = pay[pay.size()-1];
        end
        @(negedge clock);
        bus.start    = 1'b0;
        bus.ld_valid = 1'b0;

        k = 0; stalls = 0; cyc = 0; total = exp.size();
        while (k < total && cyc < 4 * total + 100) begin
            chk("pkt_data", bus.pkt_data, exp[k]);
            chk("pkt_valid", bus.pkt_valid, (k < total - 1));
            if (k == stall_at && stalls < stall_len) begin
                bus.busy = 1'b1;
                stalls++;
            end else begin
                bus.busy = ($urandom_range(99) < busy_pct);
            end
            if (!bus.busy) k++;
            cyc++;
            @(negedge clock);
        end
        bus.busy = 1'b0;
        if (k < total) chk("transfer_timeout", k, total);
        chk("done_pulse", bus.done, 1'b1);
        chk("post_pkt_valid", bus.pkt_valid, 1'b0);
        chk("post_pkt_data", bus.pkt_data, 8'h00);
        exp_pkts++;
        chk("pkt_count", bus.pkt_count, exp_pkts);
        @(negedge clock);
        chk("done_clear", bus.done, 1'b0);
        chk("start_ready", bus.start_ready, 1'b1);
        chk("idle_pkt_valid", bus.pkt_valid, 1'b0);
        pay.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{len:8, dest:2'd1, inj:1'b0, base:'h11, busy_pct:0,  stall_at:-1, stall_len:0, exp_hdr:'h21, exp_par:'h29};
        tbl[1] = '{len:8, dest:2'd1, inj:1'b0, base:'h11, busy_pct:0,  stall_at:4,  stall_len:3, exp_hdr:'h21, exp_par:'h29};
        tbl[2] = '{len:1, dest:2'd0, inj:1'b1, base:'hA5, busy_pct:0,  stall_at:-1, stall_len:0, exp_hdr:'h04, exp_par:'h5E};
        tbl[3] = '{len:1, dest:2'd2, inj:1'b0, base:-1,   busy_pct:50, stall_at:-1, stall_len:0, exp_hdr:'h06, exp_par:-1};
        tbl[4] = '{len:12, dest:2'd0, inj:1'b1, base:-1,  busy_pct:40, stall_at:-1, stall_len:0, exp_hdr:'h30, exp_par:-1};

        bus.ld_valid = 1'b0; bus.ld_data = 8'h00; bus.start = 1'b0;
        bus.start_dest = 2'd0; bus.start_err_inj = 1'b0; bus.busy = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_pkt_valid", bus.pkt_valid, 1'b0);
        chk("rst_pkt_data", bus.pkt_data, 8'h00);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_start_err", bus.start_err, 1'b0);
        chk("rst_pkt_count", bus.pkt_count, 16'd0);
        chk("rst_start_ready", bus.start_ready, 1'b1);
        chk("rst_ld_ready", bus.ld_ready, 1'b1);
        reset = 1'b0;
        @(negedge clock);

        for (int v = 0; v < 5; v++) begin
            fill(tbl[v].len, tbl[v].base);
            load(tbl[v].len);
            send(tbl[v].dest, tbl[v].inj, tbl[v].busy_pct, tbl[v].stall_at,
                 tbl[v].stall_len, 1'b0, tbl[v].exp_hdr, tbl[v].exp_par);
        end

        // Rejected starts keep the buffer for a later valid start.
        reject(2'd1);
        fill(5, -1);
        load(5);
        reject(2'd3);
        send(2'd2, 1'b0, 0, -1, 0, 1'b0, 'h16, -1);

        // A load coinciding with the start is part of that packet.
        fill(3, 'h40);
        load(2);
        send(2'd1, 1'b0, 0, -1, 0, 1'b1, 'h0D, -1);

        // Full buffer: ld_ready drops and an extra byte is ignored.
        fill(63, -1);
        load(63);
        chk("full_ld_ready", bus.ld_ready, 1'b0);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'hEE;
        @(negedge clock);
        bus.ld_valid = 1'b0;
        chk("full_ld_ready_hold", bus.ld_ready, 1'b0);
        send(2'd1, 1'b0, 20, -1, 0, 1'b0, 'hFD, -1);

        // Reset while the third payload byte is on the bus.
        fill(5, -1);
        load(5);
        bus.start = 1'b1; bus.start_dest = 2'd0; bus.start_err_inj = 1'b0;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (3) @(negedge clock);
        chk("pre_rst_data", bus.pkt_data, pay[2]);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_pkt_valid", bus.pkt_valid, 1'b0);
        chk("abort_pkt_data", bus.pkt_data, 8'h00);
        chk("abort_start_ready", bus.start_ready, 1'b1);
        chk("abort_pkt_count", bus.pkt_count, 16'd0);
        exp_pkts = 0;
        @(negedge clock);
        chk("abort_no_parity", bus.pkt_valid, 1'b0);
        reject(2'd0);
        fill(2, -1);
        load(2);
        send(2'd2, 1'b0, 0, -1, 0, 1'b0, 'h0A, -1);

        for (int r = 0; r < 10; r++) begin
            fill(int'($urandom_range(20, 1)), -1);
            load(pay.size());
            send(2'($urandom_range(2, 0)), 1'($urandom_range(1, 0)), 30, -1, 0, 1'b0, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/router_pkt_src.md
Name: router_pkt_src

Overview:
- Synthesizable packet source sitting directly upstream of router_top; drives the router's pkt_valid/data_in inputs and honours its busy output.
- Software/bench loads payload bytes into an internal buffer, then issues a start with a destination. The block emits header, payload and parity bytes in router format.
- Header format: {length[5:0], dest[1:0]}. Parity byte is the XOR of the header and all payload bytes. pkt_valid is high for header and payload, low for the parity byte.

Parameters:
- MAX_LEN, 63, payload buffer depth and maximum payload length; must be ≤63 because of the 6-bit header length field.
- CNT_W, 16, width of the sent-packet counter.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ld_valid  in  1  payload byte load strobe.
- ld_data  in  8  payload byte.
- ld_ready  out  1  high when state==IDLE and count<MAX_LEN.
- start  in  1  request to send the loaded packet.
- start_dest  in  2  destination port 0..2.
- start_err_inj  in  1  when high, the parity byte is inverted for this packet.
- start_ready  out  1  high when state==IDLE.
- busy  in  1  router busy; a byte transfers on a rising edge where busy==0 and state is HDR/PLD/PAR.
- pkt_valid  out  1  to router pkt_valid.
- pkt_data  out  8  to router data_in.
- done  out  1  one-cycle pulse after the parity byte transfers.
- start_err  out  1  one-cycle pulse when a start is rejected.
- pkt_count  out  CNT_W  packets sent since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset:
  - state=IDLE; count, rd_ptr, parity and pkt_count = 0.
  - pkt_valid=0, pkt_data=0, done=0, start_err=0.
  - Reset mid-packet aborts immediately and clears the buffer; no parity byte is sent.
- Loading:
  - In IDLE, each cycle with ld_valid&&ld_ready writes ld_data to buf[count] and increments count.
  - ld_valid while ld_ready=0 is dropped silently.
- States: IDLE, HDR, PLD, PAR. All outputs are registered.
- IDLE:
  - start with count==0 or start_dest==2'b11 → start_err pulse next cycle; stay IDLE; buffer kept.
  - Valid start → next cycle: state=HDR, pkt_valid=1, pkt_data={count[5:0],start_dest}, parity=that header, err_inj latched.
  - start and ld_valid in the same cycle: the load is accepted first, and the start uses the incremented count.
- HDR/PLD:
  - pkt_data and pkt_valid are held stable while busy==1.
  - On a transfer edge: if rd_ptr<count, next byte = buf[rd_ptr]; parity ^= that byte; rd_ptr++; state=PLD.
  - Otherwise: state=PAR, pkt_valid=0, pkt_data=parity^{8{err_inj}}.
  - Latency: header appears 1 cycle after start; each subsequent byte appears on the edge following its predecessor's transfer.
- PAR:
  - pkt_data is held while busy==1.
  - On the transfer edge: state=IDLE, pkt_data=0, done=1 for one cycle, pkt_count++, count=0, rd_ptr=0.
- Back-to-back: start_ready rises the cycle after the parity transfer. The earliest next header is 2 cycles after the parity transfer.
- Minimum packet (count=1): header, 1 payload, parity = 3 transfers.
- No bubbles: pkt_valid never drops between header and last payload byte.

Decomposition:
- Shared package router_pkg:
  - Header field widths LEN_W=6 and ADDR_W=2.
  - Invalid address constant 2'b11.
  - State encoding typedef pkt_src_state_t.
  - The same constants serve router_top and its benches.
- One natural sub-module: router_pkt_buf.
  - MAX_LEN×8 register array.
  - Write port (we, wr_addr, wr_data) and combinational read port (rd_addr, rd_data).

Test Plan:
- Load 8 bytes (0x11..0x18), start dest=1, busy=0 → pkt_data sequence 0x21,0x11..0x18, then parity 0x21^0x11^…^0x18 with pkt_valid=0; done pulses once; pkt_count=1.
- Same load with busy high for 3 cycles during the 4th payload byte → that byte is held for 4 cycles total; the sequence is otherwise unchanged; no extra transfers.
- Start with count=0, and separately start with dest=3 after loading 5 bytes → start_err pulses; pkt_valid stays 0; the 5 bytes are still sent correctly by a later start with dest=2 (header 0x16).
- start_err_inj=1 with 1 byte 0xA5, dest=0 → header 0x04, payload 0xA5, parity ~(0x04^0xA5)=0x5E.
- Load 63 bytes → ld_ready goes low and a 64th ld_valid is ignored; header=0xFD for dest=1; 65 transfers total.
- Reset asserted during the 3rd payload byte → next cycle pkt_valid=0, state IDLE, count=0; a following 2-byte packet sends correct header and parity.
